cuppa_wvb_hdr_ctrl: RTL and testbench

- Sequences one waveform-buffer channel: owns the circular write-address counter and enforces the pre-trigger fill.
- Accepts triggers and counts post-trigger samples.
- Emits one 87-bit waveform header per event to the header FIFO via valid/ready.
- Sits between the trigger logic / LTC counter and the waveform buffer RAM plus header FIFO.

---
 rtl/cuppa_wvb_hdr_ctrl.sv | 157 +++++++++++++++
 tb/tb_cuppa_wvb_hdr_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/cuppa_wvb_hdr_ctrl.sv
// Waveform-buffer channel sequencer: circular write address, pre-trigger fill, post-trigger count, header out.
// Optional dropped-trigger counter enabled by defining CUPPA_WVB_HDR_CTRL_DROP_CNT_EN.
module cuppa_wvb_hdr_ctrl #(
    parameter int P_ADR_WIDTH  = 15,
    parameter int P_LTC_WIDTH  = 48,
    parameter int P_PRE_WIDTH  = 6,
    parameter int P_POST_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    arm,
    input  logic                    trig,
    input  logic [1:0]              trig_src_in,
    input  logic                    cnst_run_in,
    input  logic [P_PRE_WIDTH-1:0]  pre_conf,
    input  logic [P_POST_WIDTH-1:0] post_conf,
    input  logic [P_LTC_WIDTH-1:0]  ltc_in,
    output logic                    wvb_wr_en,
    output logic [P_ADR_WIDTH-1:0]  wvb_wr_addr,
    output logic [P_LTC_WIDTH+2*P_ADR_WIDTH+P_PRE_WIDTH+2:0] hdr_data,
    output logic                    hdr_valid,
    input  logic                    hdr_ready,
`ifdef CUPPA_WVB_HDR_CTRL_DROP_CNT_EN
    output logic [15:0]             drop_cnt,
`endif
    output logic                    busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE_FILL,
        S_ARMED,
        S_POST,
        S_HDR
    } state_t;

    localparam logic [P_PRE_WIDTH-1:0]  PRE_ONE  = 1;
    localparam logic [P_POST_WIDTH-1:0] POST_ONE = 1;

    state_t                  state, state_nxt;
    logic [P_PRE_WIDTH-1:0]  fill_cnt, fill_nxt;
    logic [P_POST_WIDTH-1:0] post_cnt, post_nxt;
    logic [P_POST_WIDTH-1:0] post_lat;
    logic [P_PRE_WIDTH-1:0]  pre_m1;
    logic [P_ADR_WIDTH-1:0]  start_addr, stop_addr;
    logic                    evt_take;
    logic                    rearm;

    assign pre_m1     = pre_conf - PRE_ONE;
    assign start_addr = wvb_wr_addr - P_ADR_WIDTH'(pre_conf);
    assign stop_addr  = wvb_wr_addr + P_ADR_WIDTH'(post_conf);

    assign wvb_wr_en = (state != S_IDLE);
    assign busy      = (state != S_IDLE);
    assign hdr_valid = (state == S_HDR);

    always_comb begin
        state_nxt = state;
        fill_nxt  = fill_cnt;
        post_nxt  = post_cnt;
        evt_take  = 1'b0;
        rearm     = 1'b0;
        case (state)
            S_IDLE: begin
                if (arm) begin
                    rearm     = 1'b1;
                    fill_nxt  = '0;
                    state_nxt = (pre_conf == '0) ? S_ARMED : S_PRE_FILL;
                end
            end
            S_PRE_FILL: begin
                if (!arm) begin
                    state_nxt = S_IDLE;
                end else if (fill_cnt == pre_m1) begin
                    state_nxt = S_ARMED;
                end else begin
                    fill_nxt = fill_cnt + PRE_ONE;
                end
            end
            S_ARMED: begin
                // A trigger in the same cycle as disarm still captures the event
                if (trig || cnst_run_in) begin
                    evt_take  = 1'b1;
                    post_nxt  = '0;
                    state_nxt = (post_conf == '0) ? S_HDR : S_POST;
                end else if (!arm) begin
                    state_nxt = S_IDLE;
                end
            end
            S_POST: begin
                post_nxt = post_cnt + POST_ONE;
                if (post_nxt == post_lat) begin
                    state_nxt = S_HDR;
                end
            end
            S_HDR: begin
                if (hdr_ready) begin
                    fill_nxt = '0;
                    if (!arm) begin
                        state_nxt = S_IDLE;
                    end else begin
                        state_nxt = (pre_conf == '0) ? S_ARMED : S_PRE_FILL;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            fill_cnt <= '0;
            post_cnt <= '0;
        end else begin
            state    <= state_nxt;
            fill_cnt <= fill_nxt;
            post_cnt <= post_nxt;
        end
    end

    // Address free-runs whenever the buffer is being written and holds in IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wvb_wr_addr <= '0;
        end else if (state != S_IDLE) begin
            wvb_wr_addr <= wvb_wr_addr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            post_lat <= '0;
            hdr_data <= '0;
        end else if (evt_take) begin
            post_lat <= post_conf;
            hdr_data <= {pre_conf, cnst_run_in, trig_src_in, stop_addr, start_addr, ltc_in};
        end
    end

`ifdef CUPPA_WVB_HDR_CTRL_DROP_CNT_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (rearm) begin
            drop_cnt <= '0;
        end else if (trig && (state == S_PRE_FILL || state == S_POST || state == S_HDR)) begin
            drop_cnt <= sat_inc(drop_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_cuppa_wvb_hdr_ctrl.sv
// Directed bench for cuppa_wvb_hdr_ctrl; build with CUPPA_WVB_HDR_CTRL_DROP_CNT_EN to cover the drop counter.
module tb_cuppa_wvb_hdr_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        arm, trig, cnst_run_in, hdr_ready;
    logic [1:0]  trig_src_in;
    logic [5:0]  pre_conf;
    logic [7:0]  post_conf;
    logic [47:0] ltc_in;
    logic        wvb_wr_en, hdr_valid, busy;
    logic [14:0] wvb_wr_addr;
    logic [86:0] hdr_data;
`ifdef CUPPA_WVB_HDR_CTRL_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    cuppa_wvb_hdr_ctrl dut (
        .clk(clk), .rst_n(rst_n), .arm(arm), .trig(trig), .trig_src_in(trig_src_in),
        .cnst_run_in(cnst_run_in), .pre_conf(pre_conf), .post_conf(post_conf), .ltc_in(ltc_in),
        .wvb_wr_en(wvb_wr_en), .wvb_wr_addr(wvb_wr_addr), .hdr_data(hdr_data),
        .hdr_valid(hdr_valid), .hdr_ready(hdr_ready),
`ifdef CUPPA_WVB_HDR_CTRL_DROP_CNT_EN
        .drop_cnt(drop_cnt),
`endif
        .busy(busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [86:0] mk_hdr(input logic [5:0] pre, input logic cr, input logic [1:0] src,
                                           input logic [14:0] stop, input logic [14:0] start,
                                           input logic [47:0] ltc);
        return {pre, cr, src, stop, start, ltc};
    endfunction

    task automatic wait_addr(input logic [14:0] a, input int bound);
        int n = 0;
        while (wvb_wr_addr !== a && n < bound) begin
            tick();
            n++;
        end
        chk("wait_addr", wvb_wr_addr, a);
    endtask

    initial begin
        rst_n = 1'b0; arm = 1'b0; trig = 1'b0; cnst_run_in = 1'b0; hdr_ready = 1'b0;
        trig_src_in = 2'd0; pre_conf = 6'd0; post_conf = 8'd0; ltc_in = 48'd0;
        repeat (3) tick();
        chk("rst_wr_en", wvb_wr_en, 1'b0);
        chk("rst_addr", wvb_wr_addr, 15'h0);
        chk("rst_hdr_valid", hdr_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_hdr_data", hdr_data, 87'h0);
        rst_n = 1'b1;
        tick();

        // basic event: pre=4, post=10, trigger at 0x0020
        pre_conf = 6'd4; post_conf = 8'd10; arm = 1'b1;
        tick();
        chk("prefill_busy", busy, 1'b1);
        chk("prefill_wr_en", wvb_wr_en, 1'b1);
        chk("prefill_addr", wvb_wr_addr, 15'h0);
        repeat (4) tick();
        chk("armed_addr", wvb_wr_addr, 15'h4);
        wait_addr(15'h0020, 100);
        trig = 1'b1; ltc_in = 48'h123; trig_src_in = 2'd2;
        tick();
        trig = 1'b0;
        repeat (9) tick();
        chk("lat_before", hdr_valid, 1'b0);
        tick();
        chk("lat_at", hdr_valid, 1'b1);
        chk("hdr1", hdr_data, mk_hdr(6'd4, 1'b0, 2'd2, 15'h002A, 15'h001C, 48'h123));
        chk("hdr1_addr", wvb_wr_addr, 15'h002B);

        // stall 20 cycles, then handshake back to pre-fill with ignored triggers
        ltc_in = 48'h999; trig_src_in = 2'd0;
        repeat (20) tick();
        chk("stall_valid", hdr_valid, 1'b1);
        chk("stall_hdr", hdr_data, mk_hdr(6'd4, 1'b0, 2'd2, 15'h002A, 15'h001C, 48'h123));
        chk("stall_addr", wvb_wr_addr, 15'h003F);
        chk("stall_wr_en", wvb_wr_en, 1'b1);
        hdr_ready = 1'b1;
        tick();
        hdr_ready = 1'b0;
        chk("hs_valid", hdr_valid, 1'b0);
        chk("hs_addr", wvb_wr_addr, 15'h0040);
        chk("hs_busy", busy, 1'b1);
        trig = 1'b1;
        repeat (3) tick();
        trig = 1'b0;
        repeat (13) tick();
        chk("prefill_trig_ignored", hdr_valid, 1'b0);
        chk("prefill_trig_addr", wvb_wr_addr, 15'h0050);
`ifdef CUPPA_WVB_HDR_CTRL_DROP_CNT_EN
        chk("drop_prefill", drop_cnt, 16'd3);
`endif

        // wrap: trigger at 0x0002 with pre=6, post=8
        pre_conf = 6'd6; post_conf = 8'd8; ltc_in = 48'hABCDEF012345; trig_src_in = 2'd1;
        wait_addr(15'h0002, 40000);
        trig = 1'b1;
        tick();
        trig = 1'b0;
        repeat (8) tick();
        chk("wrap1_valid", hdr_valid, 1'b1);
        chk("wrap1_hdr", hdr_data, mk_hdr(6'd6, 1'b0, 2'd1, 15'h000A, 15'h7FFC, 48'hABCDEF012345));
        chk("wrap1_addr", wvb_wr_addr, 15'h000B);
        hdr_ready = 1'b1;
        tick();
        hdr_ready = 1'b0;
        repeat (6) tick();
        chk("wrap1_rearm_addr", wvb_wr_addr, 15'h0012);

        // wrap: trigger at 0x7FFA with pre=0, post=10
        pre_conf = 6'd0; post_conf = 8'd10; ltc_in = 48'h777; trig_src_in = 2'd3;
        wait_addr(15'h7FFA, 40000);
        trig = 1'b1;
        tick();
        trig = 1'b0;
        repeat (10) tick();
        chk("wrap2_valid", hdr_valid, 1'b1);
        chk("wrap2_hdr", hdr_data, mk_hdr(6'd0, 1'b0, 2'd3, 15'h0004, 15'h7FFA, 48'h777));
        chk("wrap2_addr", wvb_wr_addr, 15'h0005);

        // constant-run: one header every 2 cycles
        ltc_in = 48'h55; cnst_run_in = 1'b1; post_conf = 8'd0; hdr_ready = 1'b1;
        tick();
        chk("cr_armed_valid", hdr_valid, 1'b0);
        tick();
        chk("cr_hdr1_valid", hdr_valid, 1'b1);
        chk("cr_hdr1", hdr_data, mk_hdr(6'd0, 1'b1, 2'd3, 15'h0006, 15'h0006, 48'h55));
        tick();
        chk("cr_gap_valid", hdr_valid, 1'b0);
        tick();
        chk("cr_hdr2_valid", hdr_valid, 1'b1);
        chk("cr_hdr2", hdr_data, mk_hdr(6'd0, 1'b1, 2'd3, 15'h0008, 15'h0008, 48'h55));
        cnst_run_in = 1'b0;
        tick();
        chk("cr_stop_valid", hdr_valid, 1'b0);
        chk("cr_stop_busy", busy, 1'b1);

        // disarm in ARMED
        arm = 1'b0;
        tick();
        chk("disarm_wr_en", wvb_wr_en, 1'b0);
        chk("disarm_busy", busy, 1'b0);
        chk("disarm_addr", wvb_wr_addr, 15'h000B);
        repeat (3) tick();
        chk("idle_addr_hold", wvb_wr_addr, 15'h000B);
`ifdef CUPPA_WVB_HDR_CTRL_DROP_CNT_EN
        chk("drop_before_rearm", drop_cnt, 16'd3);
`endif

        // disarm during POST still emits the header
        arm = 1'b1; post_conf = 8'd3;
        tick();
`ifdef CUPPA_WVB_HDR_CTRL_DROP_CNT_EN
        chk("drop_rearm_clear", drop_cnt, 16'd0);
`endif
        chk("rearm_busy", busy, 1'b1);
        chk("rearm_addr", wvb_wr_addr, 15'h000B);
        trig = 1'b1;
        tick();
        trig = 1'b0; arm = 1'b0;
        repeat (2) tick();
        chk("post_disarm_busy", busy, 1'b1);
        chk("post_disarm_nohdr", hdr_valid, 1'b0);
        tick();
        chk("post_disarm_valid", hdr_valid, 1'b1);
        chk("post_disarm_hdr", hdr_data, mk_hdr(6'd0, 1'b0, 2'd3, 15'h000E, 15'h000B, 48'h55));
        tick();
        chk("post_disarm_idle", busy, 1'b0);
        chk("post_disarm_vld0", hdr_valid, 1'b0);
        chk("post_disarm_wr_en", wvb_wr_en, 1'b0);

        // triggers during POST, then asynchronous reset mid-event
        arm = 1'b1; post_conf = 8'd10; hdr_ready = 1'b0;
        tick();
        trig = 1'b1;
        tick();
        repeat (3) tick();
        trig = 1'b0;
`ifdef CUPPA_WVB_HDR_CTRL_DROP_CNT_EN
        chk("drop_post", drop_cnt, 16'd3);
`endif
        chk("mid_post_busy", busy, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_wr_en", wvb_wr_en, 1'b0);
        chk("arst_addr", wvb_wr_addr, 15'h0);
        chk("arst_hdr_valid", hdr_valid, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_hdr_data", hdr_data, 87'h0);
`ifdef CUPPA_WVB_HDR_CTRL_DROP_CNT_EN
        chk("arst_drop", drop_cnt, 16'd0);
`endif
        arm = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
